// File: rtl/img_window_sched_pkg.sv
// Shared state encoding, default geometry and window helper for the image window scheduler.
package img_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } sched_state_e;

    localparam int unsigned PIX_W          = 8;
    localparam int unsigned DEF_IMG_W      = 225;
    localparam int unsigned DEF_IMG_H      = 225;
    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_X0         = 207;
    localparam int unsigned DEF_Y0         = 127;

    // Unsigned half-open span test: lo <= v < lo+len.
    function automatic logic in_span(input logic [31:0] v, input logic [31:0] lo,
                                     input logic [31:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage

// File: rtl/raster_pos_cnt.sv
// Raster x/y position tracker driven by the DE stream; vsync low returns to the origin.
module raster_pos_cnt
    import img_sched_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_vsync,
    input  logic                        i_de,
    output logic [$clog2(H_ACTIVE)-1:0] o_x,
    output logic [$clog2(V_ACTIVE)-1:0] o_y,
    output logic                        o_de_dly
);

    localparam int unsigned XW = $clog2(H_ACTIVE);
    localparam int unsigned YW = $clog2(V_ACTIVE);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          de_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!i_vsync) begin
            x_d = '0;
            y_d = '0;
        end else if (de_q && !i_de) begin
            x_d = '0;
            if (y_q != YW'(V_ACTIVE - 1)) y_d = y_q + YW'(1);
        end else if (i_de) begin
            x_d = x_q + XW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            de_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            de_q <= i_de;
        end
    end

    assign o_x      = x_q;
    assign o_y      = y_q;
    assign o_de_dly = de_q;

endmodule

// File: rtl/img_window_sched.sv
// Display-side scheduler: pops the loader FIFO for in-window pixels and emits a registered pixel/DE stream.
// Optional statistics outputs (o_uf_cnt, o_frame_cnt) are built when IMG_SCHED_STATS_EN is defined.
module img_window_sched
    import img_sched_pkg::*;
#(
    parameter int unsigned   IMG_W    = DEF_IMG_W,
    parameter int unsigned   IMG_H    = DEF_IMG_H,
    parameter int unsigned   H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned   V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned   X0       = DEF_X0,
    parameter int unsigned   Y0       = DEF_Y0,
    parameter logic [PIX_W-1:0] BG_VAL = 8'h00,
    parameter logic [PIX_W-1:0] UF_VAL = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic [PIX_W-1:0] i_pix_data,
    input  logic             i_pix_valid,
    output logic             o_next,
    output logic [PIX_W-1:0] o_pix,
    output logic             o_de,
    output logic             o_frame_done,
    output logic             o_underflow
`ifdef IMG_SCHED_STATS_EN
    ,
    output logic [15:0]      o_uf_cnt,
    output logic [15:0]      o_frame_cnt
`endif
);

    localparam logic [15:0] LAST_IDX = 16'(IMG_W * IMG_H - 1);

    sched_state_e                  state_q;
    logic [$clog2(H_ACTIVE)-1:0]   x;
    logic [$clog2(V_ACTIVE)-1:0]   y;
    logic [15:0]                   win_cnt_q;
    logic [PIX_W-1:0]              pix_d;
    logic                          in_win, win_act, pop, underflow, last_pos;

    raster_pos_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vsync  (i_vsync),
        .i_de     (i_de),
        .o_x      (x),
        .o_y      (y),
        .o_de_dly (o_de)
    );

    assign in_win    = i_de && in_span(32'(x), X0, IMG_W) && in_span(32'(y), Y0, IMG_H);
    // vsync low gates the window so the loader is never popped while it clears its pointers
    assign win_act   = (state_q == ACTIVE) && i_vsync && in_win;
    assign pop       = win_act && i_pix_valid;
    assign underflow = win_act && !i_pix_valid;
    assign last_pos  = (32'(x) == X0 + IMG_W - 1) && (32'(y) == Y0 + IMG_H - 1);
    assign o_next    = pop;

    always_comb begin
        pix_d = BG_VAL;
        if (pop)            pix_d = i_pix_data;
        else if (underflow) pix_d = UF_VAL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            o_pix        <= BG_VAL;
            o_frame_done <= 1'b0;
            o_underflow  <= 1'b0;
            win_cnt_q    <= '0;
        end else begin
            o_pix        <= pix_d;
            o_frame_done <= pop && (win_cnt_q == LAST_IDX);
            if (underflow) o_underflow <= 1'b1;
            if (pop)       win_cnt_q   <= win_cnt_q + 16'd1;
            case (state_q)
                IDLE:    ;
                ARMED: begin
                    win_cnt_q <= '0;
                    if (i_vsync) state_q <= ACTIVE;
                end
                ACTIVE:  if (pop && last_pos) state_q <= DONE;
                DONE:    ;
                default: state_q <= IDLE;
            endcase
            // Any vsync low (including mid-frame) re-arms for the next frame
            if (!i_vsync) state_q <= ARMED;
        end
    end

`ifdef IMG_SCHED_STATS_EN
    logic [15:0] uf_cnt_q, frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uf_cnt_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (!i_vsync && state_q != ARMED)
                uf_cnt_q <= '0;
            else if (underflow && uf_cnt_q != 16'hFFFF)
                uf_cnt_q <= uf_cnt_q + 16'd1;
            if (o_frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign o_uf_cnt    = uf_cnt_q;
    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/img_window_sched.md
# img_window_sched

Display-side scheduler for the grayscale image loader FIFO. It tracks raster position from the display timing stream and places an IMG_W×IMG_H image window at a fixed origin inside the active area. It issues `o_next` pops to the loader only for in-window pixels, and emits a registered pixel/DE stream to the display encoder, filling with background outside the window. It sits between the loader (`o_data`/`o_valid`/`i_next`) and the video output stage, sharing the loader's `i_vsync` frame sync.

## Interface
- `IMG_W`, 225: image width in pixels.
- `IMG_H`, 225: image height in lines.
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `X0`, 207: window left column. Requires X0+IMG_W ≤ H_ACTIVE.
- `Y0`, 127: window top line. Requires Y0+IMG_H ≤ V_ACTIVE.
- `BG_VAL`, 8'h00: fill value outside the window.
- `UF_VAL`, 8'hFF: fill value on underflow.

Ports:
- `clk` in 1: pixel clock; the single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `i_vsync` in 1: active-low frame sync, same signal the loader receives.
- `i_de` in 1: active-video enable from display timing.
- `i_pix_data` in 8: loader `o_data`, first-word-fall-through.
- `i_pix_valid` in 1: loader `o_valid`.
- `o_next` out 1: pop request to loader `i_next`. Combinational.
- `o_pix` out 8: output pixel, registered.
- `o_de` out 1: `i_de` delayed one cycle, aligned with `o_pix`.
- `o_frame_done` out 1: one-cycle pulse when the last window pixel is popped.
- `o_underflow` out 1: sticky flag, set on any in-window underflow.

## Operation
- **Position tracking.** Counters `x` (width clog2(H_ACTIVE)) and `y` (width clog2(V_ACTIVE)).
  - `x` increments on each `i_de`=1 cycle.
  - On a DE falling edge (`de_q`=1, `i_de`=0): `x`←0 and `y`←y+1.
  - `y` saturates at V_ACTIVE-1.
  - `i_vsync`=0 forces x=0, y=0.
- **Window predicate.** in_win = `i_de` && X0≤x<X0+IMG_W && Y0≤y<Y0+IMG_H. All comparisons are unsigned.
- **State machine.**
  - IDLE: entered after reset. Goes to ARMED when `i_vsync`=0 is sampled.
  - ARMED: waits in vsync. Goes to ACTIVE on the first cycle with `i_vsync`=1.
  - ACTIVE: goes to DONE after the pop of the pixel at (X0+IMG_W-1, Y0+IMG_H-1).
  - DONE: goes to ARMED when `i_vsync`=0.
  - In any state other than IDLE, `i_vsync`=0 forces ARMED. This is a mid-frame resync.
- **Pop rule.** `o_next` = (state==ACTIVE) && in_win && `i_pix_valid`. It is never asserted outside ACTIVE.
- **Pixel select**, registered into `o_pix`:
  - in_win && ACTIVE && valid → `i_pix_data`.
  - in_win && ACTIVE && !valid → UF_VAL, no pop; sets `o_underflow`.
  - otherwise → BG_VAL.
  - Underflow does not skip a source pixel: the next pop delivers the next FIFO word, so the image shifts.
- **Underflow flag.** `o_underflow` clears only on `rst_n`. It is not cleared by vsync.
- **Window pixel counter.** Width 16 bits; counts pops. `o_frame_done` fires when it reaches IMG_W*IMG_H-1 with a pop. The counter is cleared in ARMED.

## Timing
- **Reset values** (`rst_n`=0 at a clk edge):
  - state=IDLE, x=0, y=0, `o_pix`=BG_VAL, `o_de`=0, `o_frame_done`=0, `o_underflow`=0.
  - `o_next`=0, because state≠ACTIVE.
- **Latency.** `o_pix`/`o_de` lag `i_de` by exactly 1 cycle. The loader `rd_ptr` advances on the same edge at which `o_pix` captures `i_pix_data`.
- **Pop/vsync.** `o_next` is 0 in any cycle with `i_vsync`=0. This avoids popping while the loader clears its pointers.
- **Simultaneous events.**
  - DE falling edge coincident with vsync low: vsync wins, and y=0.
  - Last pop and vsync low in the same cycle: `o_frame_done` is not pulsed.
- **Frame-done pulse.** Exactly one cycle, registered, one cycle after the final pop edge.

## Configuration
- `IMG_SCHED_STATS_EN` defined:
  - Adds output `o_uf_cnt` [15:0], a saturating count of underflow cycles, cleared on ARMED entry.
  - Adds output `o_frame_cnt` [15:0], counting `o_frame_done` pulses and wrapping at 0xFFFF.
  - Both reset to 0.
- Undefined: neither port nor its counter exists. All other behaviour is identical.

## Structure
- Package `img_sched_pkg`:
  - `sched_state_e` enum {IDLE, ARMED, ACTIVE, DONE}.
  - Default geometry localparams: IMG_W/H, H/V_ACTIVE, X0, Y0.
  - PIX_W=8.
- Sub-module `raster_pos_cnt` holds the x/y counters and DE edge detect, parameterised by H_ACTIVE/V_ACTIVE. The top level holds the FSM, pop logic, output register and stats.

## Test plan
- Reset, then vsync low 2 cycles, then 480 lines × 640 DE with a loader model that is always valid → exactly 50625 pops. `o_pix`=BG_VAL outside the window. Pixel at (207,127) is the first FIFO word. `o_frame_done` pulses once. `o_underflow`=0.
- Withhold `i_pix_valid` for 3 in-window cycles on line Y0+10 → 3 cycles of `o_pix`=8'hFF, no pops during them, `o_underflow`=1 sticky. With the macro: `o_uf_cnt`=3.
- Vsync low mid-frame at line 200 → `o_next`=0 during vsync, state=ARMED, next frame's first window pixel is popped at (207,127), no `o_frame_done` for the aborted frame.
- `rst_n` low during ACTIVE → next-edge outputs equal reset values, state=IDLE, no pops until vsync low then high.
- DE fall and vsync low in the same cycle → y=0, x=0. Check `o_de` alignment: `o_de` = `i_de` delayed by 1 cycle throughout.
- Two back-to-back frames with the macro → `o_frame_cnt`=2, `o_uf_cnt` cleared at the second ARMED entry.
